// File: rtl/noc_xbar.sv
// noc_xbar: NoC crossbar between the per-CPU cpu_to_noc / noc_to_cpu streams.
//
// Each input stream feeds its own FIFO. The FIFO head is routed by its
// destination field word[DEST_LSB +: DEST_W]: a destination below N_PORTS
// requests that output, anything else is dropped and counted. Every output
// has a round-robin arbiter feeding a single-entry output register.
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   in_vld    [N_PORTS]              per-input valid
//   in_rdy    [N_PORTS]              per-input ready (!full, 0 during reset)
//   in_data   [N_PORTS*DATA_WIDTH]   input words, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_vld   [N_PORTS]              per-output valid
//   out_rdy   [N_PORTS]              per-output ready
//   out_data  [N_PORTS*DATA_WIDTH]   output words, same slicing as in_data
//   drop_cnt  [16]                   saturating count of dropped words
//   busy                             any FIFO or output register holds data
//
// Optional build macro NOC_XBAR_TRACE_EN: adds simulation-only transfer/drop
// trace prints and a per-output source index register. Port behaviour is
// the same with or without it.

module noc_xbar #(
    parameter int unsigned N_PORTS    = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DEST_LSB   = 56,
    parameter int unsigned DEST_W     = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_PORTS-1:0]              in_vld,
    output logic [N_PORTS-1:0]              in_rdy,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   in_data,
    output logic [N_PORTS-1:0]              out_vld,
    input  logic [N_PORTS-1:0]              out_rdy,
    output logic [N_PORTS*DATA_WIDTH-1:0]   out_data,
    output logic [15:0]                     drop_cnt,
    output logic                            busy
);

    localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    // Destination compare width, wide enough for both the field and N_PORTS.
    localparam int unsigned CW = (DEST_W > 32) ? DEST_W : 32;

    logic [N_PORTS-1:0]    fifo_full;
    logic [N_PORTS-1:0]    fifo_nempty;
    logic [N_PORTS-1:0]    push;
    logic [N_PORTS-1:0]    pop;
    logic [N_PORTS-1:0]    drop;
    logic [DATA_WIDTH-1:0] head [N_PORTS];
    logic [CW-1:0]         dest_ext [N_PORTS];
    logic [N_PORTS-1:0]    req [N_PORTS];      // req[d][i]: head of input i wants output d

    logic [N_PORTS-1:0]    grant_vld;
    logic [PW-1:0]         grant_idx [N_PORTS];
    logic [N_PORTS-1:0]    load;

    logic [N_PORTS-1:0]    out_vld_q;
    logic [DATA_WIDTH-1:0] out_data_q [N_PORTS];
    logic [PW-1:0]         ptr_q [N_PORTS];
    logic [15:0]           drop_cnt_q;
    logic [15:0]           drop_cnt_d;
    logic                  rdy_en_q;

    // Keeps in_rdy low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    assign in_rdy = {N_PORTS{rdy_en_q}} & ~fifo_full;
    assign push   = in_vld & in_rdy;

    // Per-input FIFOs
    for (genvar i = 0; i < N_PORTS; i++) begin : g_fifo
        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0]         wr_ptr_q;
        logic [AW-1:0]         rd_ptr_q;
        logic [AW:0]           cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                // Power-of-two depth: pointers wrap naturally.
                if (push[i]) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop[i])  rd_ptr_q <= rd_ptr_q + 1'b1;
                cnt_q <= cnt_q + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
            end
        end

        // Storage needs no reset; the pointers define what is valid.
        always_ff @(posedge clk) begin
            if (push[i]) mem[wr_ptr_q] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end

        assign fifo_full[i]   = (cnt_q == (AW+1)'(FIFO_DEPTH));
        assign fifo_nempty[i] = (cnt_q != '0);
        assign head[i]        = mem[rd_ptr_q];
    end

    // Destination decode
    always_comb begin
        for (int d = 0; d < N_PORTS; d++) req[d] = '0;
        drop = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            dest_ext[i] = CW'(head[i][DEST_LSB +: DEST_W]);
            drop[i]     = fifo_nempty[i] && (dest_ext[i] >= CW'(N_PORTS));
            for (int d = 0; d < N_PORTS; d++) begin
                req[d][i] = fifo_nempty[i] && (dest_ext[i] == CW'(d));
            end
        end
    end

    // Round-robin arbiters: first requester at or after ptr_q[d], with wrap.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_vld = '0;
        load      = '0;
        for (int d = 0; d < N_PORTS; d++) begin
            grant_idx[d] = '0;
            for (int k = 0; k < N_PORTS; k++) begin
                idx = (int'(ptr_q[d]) + k) % N_PORTS;
                if (!grant_vld[d] && req[d][idx]) begin
                    grant_vld[d] = 1'b1;
                    grant_idx[d] = PW'(idx);
                end
            end
            load[d] = grant_vld[d] && (!out_vld_q[d] || out_rdy[d]);
        end
    end

    // A head targets a single output, so at most one source of pop per FIFO.
    always_comb begin
        pop = drop;
        for (int d = 0; d < N_PORTS; d++) begin
            if (load[d]) pop[grant_idx[d]] = 1'b1;
        end
    end

    // Several inputs can drop in one cycle; sum them, then saturate.
    always_comb begin
        logic [16:0] sum;
        sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < N_PORTS; i++) sum = sum + 17'(drop[i]);
        drop_cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= '0;
            drop_cnt_q <= '0;
            for (int d = 0; d < N_PORTS; d++) begin
                out_data_q[d] <= '0;
                ptr_q[d]      <= '0;
            end
        end else begin
            drop_cnt_q <= drop_cnt_d;
            for (int d = 0; d < N_PORTS; d++) begin
                if (load[d]) begin
                    out_vld_q[d]  <= 1'b1;
                    out_data_q[d] <= head[grant_idx[d]];
                    ptr_q[d]      <= (grant_idx[d] == PW'(N_PORTS - 1)) ? '0
                                                                       : grant_idx[d] + 1'b1;
                end else if (out_rdy[d]) begin
                    out_vld_q[d] <= 1'b0;
                end
            end
        end
    end

    for (genvar d = 0; d < N_PORTS; d++) begin : g_out
        assign out_data[d*DATA_WIDTH +: DATA_WIDTH] = out_data_q[d];
    end

    assign out_vld  = out_vld_q;
    assign drop_cnt = drop_cnt_q;
    assign busy     = (|fifo_nempty) | (|out_vld_q);

`ifdef NOC_XBAR_TRACE_EN
    logic [PW-1:0] src_q [N_PORTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < N_PORTS; d++) src_q[d] <= '0;
        end else begin
            for (int d = 0; d < N_PORTS; d++) begin
                if (load[d]) src_q[d] <= grant_idx[d];
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < N_PORTS; d++) begin
                if (out_vld_q[d] && out_rdy[d]) begin
                    $display("%t [noc] in%0d -> out%0d 0x%016x", $time, src_q[d], d,
                             out_data_q[d]);
                end
            end
            for (int i = 0; i < N_PORTS; i++) begin
                if (drop[i]) $display("%t [noc] in%0d drop dest=%0d", $time, i, dest_ext[i]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_xbar.sv
// Directed testbench for noc_xbar (N_PORTS=4, DATA_WIDTH=64, FIFO_DEPTH=4).
// Input words are {dest[7:0], src[7:0], 40'h0, base+seq}; delivered words are
// recorded as {port[3:0], data} in the order they leave the crossbar.

module tb_noc_xbar;

    logic         clk;
    logic         rst_n;
    logic [3:0]   in_vld;
    logic [3:0]   in_rdy;
    logic [255:0] in_data;
    logic [3:0]   out_vld;
    logic [3:0]   out_rdy;
    logic [255:0] out_data;
    logic [15:0]  drop_cnt;
    logic         busy;

    noc_xbar #(
        .N_PORTS    (4),
        .DATA_WIDTH (64),
        .FIFO_DEPTH (4),
        .DEST_LSB   (56),
        .DEST_W     (8)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          failures;
    int          n_w  [4];
    int          sent [4];
    logic [7:0]  dst  [4];
    logic [7:0]  base [4];
    logic [71:0] rx [$];
    logic        saw;

    always @(posedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (rst_n && out_vld[d] && out_rdy[d]) rx.push_back({4'(d), out_data[d*64 +: 64]});
        end
    end

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int i, input int s);
        return {dst[i], 8'(i), 40'h0, base[i] + 8'(s)};
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            in_vld[i]          = (sent[i] < n_w[i]);
            in_data[i*64 +: 64] = mk(i, sent[i]);
        end
    endtask

    task automatic step();
        logic [3:0] acc;
        @(posedge clk);
        acc = in_vld & in_rdy;
        #1;
        for (int i = 0; i < 4; i++) if (acc[i]) sent[i]++;
        drive();
    endtask

    task automatic clear();
        for (int i = 0; i < 4; i++) begin
            n_w[i] = 0; sent[i] = 0; dst[i] = 8'h0; base[i] = 8'h0;
        end
        rx.delete();
        drive();
    endtask

    task automatic wait_rx(input string tag, input int cnt, input int budget);
        int k;
        k = 0;
        while (rx.size() < cnt && k < budget) begin
            step();
            k++;
        end
        check_eq(tag, 72'(rx.size()), 72'(cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        in_vld   = '0;
        in_data  = '0;
        out_rdy  = 4'hF;
        clear();

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_out_vld", 72'(out_vld), 72'h0);
        check_eq("rst_in_rdy", 72'(in_rdy), 72'h0);
        check_eq("rst_drop_cnt", 72'(drop_cnt), 72'h0);
        check_eq("rst_busy", 72'(busy), 72'h0);
        check_eq("rst_out_data", 72'(out_data[63:0]), 72'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_eq("rdy_before_edge", 72'(in_rdy), 72'h0);
        step();
        check_eq("rdy_after_release", 72'(in_rdy), 72'hF);

        // Basic route in0 -> out2
        n_w[0] = 1; dst[0] = 8'h02; base[0] = 8'hAA;
        drive();
        step();
        check_eq("basic_e0_vld", 72'(out_vld), 72'h0);
        check_eq("basic_e0_busy", 72'(busy), 72'h1);
        step();
        check_eq("basic_e1_vld", 72'(out_vld), 72'h4);
        check_eq("basic_e1_data", 72'(out_data[128 +: 64]), 72'h0200_0000_0000_00AA);
        step();
        check_eq("basic_idle_vld", 72'(out_vld), 72'h0);
        check_eq("basic_idle_busy", 72'(busy), 72'h0);
        check_eq("basic_rx_cnt", 72'(rx.size()), 72'h1);
        check_eq("basic_rx", rx[0], {4'd2, 64'h0200_0000_0000_00AA});
        clear();

        // Arbitration: in0, in1, in3 -> out1, expect 0,1,3 rotation at 1 word/cycle
        n_w[0] = 6; n_w[1] = 6; n_w[3] = 6;
        dst[0] = 8'h01; dst[1] = 8'h01; dst[3] = 8'h01;
        drive();
        repeat (20) step();
        check_eq("arb_tput", 72'(rx.size()), 72'd18);
        for (int r = 0; r < 6; r++) begin
            check_eq($sformatf("arb_r%0d_in0", r), rx[3*r],     {4'd1, mk(0, r)});
            check_eq($sformatf("arb_r%0d_in1", r), rx[3*r + 1], {4'd1, mk(1, r)});
            check_eq($sformatf("arb_r%0d_in3", r), rx[3*r + 2], {4'd1, mk(3, r)});
        end
        clear();

        // Backpressure: out0 blocked, in2 streams 6 words
        out_rdy = 4'b1110;
        n_w[2] = 6; dst[2] = 8'h00; base[2] = 8'h10;
        drive();
        repeat (8) step();
        check_eq("bp_out_vld0", 72'(out_vld[0]), 72'h1);
        check_eq("bp_out_data0", 72'(out_data[63:0]), 72'(mk(2, 0)));
        check_eq("bp_in_rdy2", 72'(in_rdy[2]), 72'h0);
        check_eq("bp_sent", 72'(sent[2]), 72'd5);
        check_eq("bp_rx_none", 72'(rx.size()), 72'h0);
        out_rdy = 4'hF;
        wait_rx("bp_drain", 6, 40);
        for (int s = 0; s < 6; s++) begin
            check_eq($sformatf("bp_w%0d", s), rx[s], {4'd0, mk(2, s)});
        end
        clear();

        // Drop: dest 7 is out of range
        n_w[1] = 1; dst[1] = 8'h07;
        drive();
        saw = 1'b0;
        repeat (4) begin
            step();
            saw |= |out_vld;
        end
        check_eq("drop_no_vld", 72'(saw), 72'h0);
        check_eq("drop_cnt1", 72'(drop_cnt), 72'h1);
        check_eq("drop_busy", 72'(busy), 72'h0);
        clear();
        n_w[1] = 1; dst[1] = 8'h03; base[1] = 8'h55;
        drive();
        wait_rx("drop_next_cnt", 1, 10);
        check_eq("drop_next", rx[0], {4'd3, mk(1, 0)});
        check_eq("drop_cnt_kept", 72'(drop_cnt), 72'h1);
        clear();

        // Wrap-around: 20 words in3 -> out0
        n_w[3] = 20; dst[3] = 8'h00; base[3] = 8'h20;
        drive();
        wait_rx("wrap_cnt", 20, 60);
        for (int s = 0; s < 20; s++) begin
            check_eq($sformatf("wrap_w%0d", s), rx[s], {4'd0, mk(3, s)});
        end
        clear();

        // Reset mid-stream with all outputs holding and all FIFOs occupied
        out_rdy = 4'h0;
        for (int i = 0; i < 4; i++) begin
            n_w[i] = 3; dst[i] = 8'(i); base[i] = 8'h80;
        end
        drive();
        repeat (6) step();
        check_eq("mid_out_vld", 72'(out_vld), 72'hF);
        check_eq("mid_busy", 72'(busy), 72'h1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_vld", 72'(out_vld), 72'h0);
        check_eq("mid_rst_drop", 72'(drop_cnt), 72'h0);
        check_eq("mid_rst_rdy", 72'(in_rdy), 72'h0);
        check_eq("mid_rst_busy", 72'(busy), 72'h0);
        clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_rdy = 4'hF;
        // in1 and in3 race for out2: a pointer restarted at 0 picks in1 first.
        n_w[1] = 1; n_w[3] = 1; dst[1] = 8'h02; dst[3] = 8'h02; base[1] = 8'h40;
        base[3] = 8'h60;
        drive();
        wait_rx("post_cnt", 2, 20);
        repeat (5) step();
        check_eq("post_no_stale", 72'(rx.size()), 72'd2);
        check_eq("post_first", rx[0], {4'd2, mk(1, 0)});
        check_eq("post_second", rx[1], {4'd2, mk(3, 0)});
        check_eq("post_busy", 72'(busy), 72'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
